// File: rtl/rr_writeback_stream_arbiter_if.sv
// rtl/rr_writeback_stream_arbiter_if.sv - two-source writeback stream bundle
// The slave modport is the arbiter view, the master modport drives sources and sinks the output.
interface rr_writeback_stream_arbiter_if #(
  parameter int DATA_WIDTH = 512,
  parameter int LEN_WIDTH  = 10
);
  logic                  src0_valid;
  logic [DATA_WIDTH-1:0] src0_data;
  logic [LEN_WIDTH-1:0]  src0_len;
  logic                  src0_ready;

  logic                  src1_valid;
  logic [DATA_WIDTH-1:0] src1_data;
  logic [LEN_WIDTH-1:0]  src1_len;
  logic                  src1_ready;

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [LEN_WIDTH-1:0]  out_len;
  logic                  out_src;
  logic                  out_ready;

  modport slave (
    input  src0_valid, src0_data, src0_len,
    output src0_ready,
    input  src1_valid, src1_data, src1_len,
    output src1_ready,
    output out_valid, out_data, out_len, out_src,
    input  out_ready
  );

  modport master (
    output src0_valid, src0_data, src0_len,
    input  src0_ready,
    output src1_valid, src1_data, src1_len,
    input  src1_ready,
    input  out_valid, out_data, out_len, out_src,
    output out_ready
  );
endinterface

// File: rtl/rr_writeback_stream_arbiter.sv
// rtl/rr_writeback_stream_arbiter.sv - weighted round-robin merge of two writeback streams
// One registered output stage; per-source saturating beat counters.
module rr_writeback_stream_arbiter #(
  parameter int DATA_WIDTH = 512,
  parameter int LEN_WIDTH  = 10,
  parameter int WEIGHT0    = 4,
  parameter int WEIGHT1    = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rstn,
  rr_writeback_stream_arbiter_if.slave bus,
  output logic [CNT_WIDTH-1:0]         cnt0,
  output logic [CNT_WIDTH-1:0]         cnt1
);

  localparam logic [7:0] W0 = 8'(WEIGHT0);
  localparam logic [7:0] W1 = 8'(WEIGHT1);

  typedef enum logic {
    GNT_SRC0 = 1'b0,
    GNT_SRC1 = 1'b1
  } gnt_e;

  gnt_e                  gnt_q;
  gnt_e                  gnt_oth;
  logic [7:0]            credit_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [LEN_WIDTH-1:0]  out_len_q;
  logic                  out_src_q;
  logic [CNT_WIDTH-1:0]  cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0]  cnt1_q, cnt1_d;

  logic       load_en;
  logic       acc0, acc1, accept;
  logic       cur_valid, oth_valid;
  logic [7:0] cur_weight, oth_weight;

  assign load_en = !out_valid_q || bus.out_ready;

  // Ready is gated by reset so nothing upstream sees a handshake that is not taken.
  assign acc0   = rstn && load_en && (gnt_q == GNT_SRC0) && bus.src0_valid;
  assign acc1   = rstn && load_en && (gnt_q == GNT_SRC1) && bus.src1_valid;
  assign accept = acc0 || acc1;

  assign cur_valid  = (gnt_q == GNT_SRC0) ? bus.src0_valid : bus.src1_valid;
  assign oth_valid  = (gnt_q == GNT_SRC0) ? bus.src1_valid : bus.src0_valid;
  assign cur_weight = (gnt_q == GNT_SRC0) ? W0 : W1;
  assign oth_weight = (gnt_q == GNT_SRC0) ? W1 : W0;
  assign gnt_oth    = (gnt_q == GNT_SRC0) ? GNT_SRC1 : GNT_SRC0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      gnt_q    <= GNT_SRC0;
      credit_q <= W0;
    end else if (load_en) begin
      if (cur_valid) begin
        // The last beat of a turn hands over in the same edge, so no bubble.
        if (credit_q == 8'd1) begin
          if (oth_valid) begin
            gnt_q    <= gnt_oth;
            credit_q <= oth_weight;
          end else begin
            credit_q <= cur_weight;
          end
        end else begin
          credit_q <= credit_q - 8'd1;
        end
      end else if (oth_valid) begin
        gnt_q    <= gnt_oth;
        credit_q <= oth_weight;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
    end else if (load_en) begin
      out_valid_q <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (load_en && accept) begin
      out_data_q <= acc1 ? bus.src1_data : bus.src0_data;
      out_len_q  <= acc1 ? bus.src1_len : bus.src0_len;
      out_src_q  <= acc1;
    end
  end

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (acc0 && (cnt0_q != {CNT_WIDTH{1'b1}})) cnt0_d = cnt0_q + CNT_WIDTH'(1);
    if (acc1 && (cnt1_q != {CNT_WIDTH{1'b1}})) cnt1_d = cnt1_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign bus.src0_ready = acc0;
  assign bus.src1_ready = acc1;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_len    = out_len_q;
  assign bus.out_src    = out_src_q;
  assign cnt0           = cnt0_q;
  assign cnt1           = cnt1_q;

`ifndef SYNTHESIS
  a_out_stable: assert property (@(posedge clk) disable iff (!rstn)
    (rstn && out_valid_q && !bus.out_ready) |=>
      (out_valid_q && $stable(out_data_q) && $stable(out_len_q) && $stable(out_src_q)));
  a_one_ready: assert property (@(posedge clk) !(acc0 && acc1));
  a_credit_nz: assert property (@(posedge clk) disable iff (!rstn) credit_q != 8'd0);
`endif

endmodule

// File: tb/tb_rr_writeback_stream_arbiter.sv
// tb/tb_rr_writeback_stream_arbiter.sv - directed bench with a turn-based arbiter model
module tb_rr_writeback_stream_arbiter;
  localparam int DW   = 32;
  localparam int LW   = 10;
  localparam int W0   = 4;
  localparam int W1   = 1;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  rr_writeback_stream_arbiter_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();
  logic [CW-1:0] cnt0, cnt1;

  rr_writeback_stream_arbiter #(
    .DATA_WIDTH(DW), .LEN_WIDTH(LW), .WEIGHT0(W0), .WEIGHT1(W1), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .cnt0(cnt0), .cnt1(cnt1)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int            seq0 = 0, seq1 = 0;
  int            log_src[$];
  int            acc_log[$];

  logic rst_v = 1'b0, rdy_v = 1'b1, started = 1'b0;

  // Model: owner of the current turn and beats it has used so far.
  logic          m_ov = 1'b0, m_os = 1'b0;
  logic [DW-1:0] m_od = '0;
  logic [LW-1:0] m_ol = '0;
  int            m_own = 0, m_used = 0, m_c0 = 0, m_c1 = 0;

  function automatic logic [LW-1:0] blen(input logic [DW-1:0] d);
    return d[LW-1:0] ^ {2'b00, d[31:24]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int src, input int n);
    for (int i = 0; i < n; i++) begin
      if (src == 0) begin q0.push_back({8'hA0, 24'(seq0)}); seq0++; end
      else          begin q1.push_back({8'hB1, 24'(seq1)}); seq1++; end
    end
  endtask

  task automatic cycle();
    logic v0, v1, le, e0, e1;
    logic [DW-1:0] b;
    @(negedge clk);
    rstn = rst_v;
    v0 = q0.size() > 0;
    v1 = q1.size() > 0;
    bus.src0_valid = v0;
    bus.src0_data  = v0 ? q0[0] : '0;
    bus.src0_len   = blen(bus.src0_data);
    bus.src1_valid = v1;
    bus.src1_data  = v1 ? q1[0] : '0;
    bus.src1_len   = blen(bus.src1_data);
    bus.out_ready  = rdy_v;
    #1;
    if (started) begin
      check("out_valid", bus.out_valid, m_ov);
      if (m_ov) begin
        check("out_data", bus.out_data, m_od);
        check("out_len", bus.out_len, m_ol);
        check("out_src", bus.out_src, m_os);
      end
      check("cnt0", cnt0, m_c0);
      check("cnt1", cnt1, m_c1);
    end
    le = !m_ov || rdy_v;
    e0 = rst_v && le && (m_own == 0) && v0;
    e1 = rst_v && le && (m_own == 1) && v1;
    check("src0_ready", bus.src0_ready, e0);
    check("src1_ready", bus.src1_ready, e1);
    if (started && rst_v && m_ov && rdy_v) log_src.push_back(int'(m_os));
    if (!rst_v) begin
      m_ov = 0; m_own = 0; m_used = 0; m_c0 = 0; m_c1 = 0;
    end else if (le) begin
      if (e0 || e1) begin
        if (e1) begin b = q1.pop_front(); if (m_c1 < CMAX) m_c1++; end
        else    begin b = q0.pop_front(); if (m_c0 < CMAX) m_c0++; end
        m_ov = 1; m_od = b; m_ol = blen(b); m_os = e1;
        m_used++;
        if (m_used == ((m_own == 1) ? W1 : W0)) begin
          m_used = 0;
          if ((m_own == 1) ? v0 : v1) m_own = 1 - m_own;
        end
        acc_log.push_back(e1 ? 1 : 0);
      end else begin
        m_ov = 0;
        if ((m_own == 1) ? v0 : v1) begin m_own = 1 - m_own; m_used = 0; end
        acc_log.push_back(2);
      end
    end else begin
      acc_log.push_back(3);
    end
    started = 1'b1;
  endtask

  task automatic do_reset();
    rst_v = 1'b0;
    q0.delete();
    q1.delete();
    cycle();
    rst_v = 1'b1;
    rdy_v = 1'b1;
    log_src.delete();
    acc_log.delete();
  endtask

  initial begin
    int pat[5];
    int exp4[9];
    pat  = '{0, 0, 0, 0, 1};
    exp4 = '{0, 0, 2, 1, 1, 0, 0, 2, 1};
    rstn = 1'b0;
    bus.src0_valid = 1'b0; bus.src0_data = '0; bus.src0_len = '0;
    bus.src1_valid = 1'b0; bus.src1_data = '0; bus.src1_len = '0;
    bus.out_ready = 1'b1;
    do_reset();
    do_reset();

    // src0 alone: ten back-to-back beats
    push(0, 10);
    for (int k = 0; k < 13; k++) cycle();
    for (int i = 0; i < 10; i++) check("s1_acc_no_bubble", acc_log[i], 0);
    check("s1_beats_out", log_src.size(), 10);
    check("s1_cnt0", cnt0, 10);
    check("s1_cnt1", cnt1, 0);

    // both busy: 4:1 interleave with no idle cycle
    do_reset();
    push(0, 16); push(1, 4);
    for (int k = 0; k < 23; k++) cycle();
    check("s2_beats_out", log_src.size(), 20);
    for (int i = 0; i < 20; i++) begin
      check("s2_acc_pattern", acc_log[i], pat[i % 5]);
      check("s2_out_src_pattern", log_src[i], pat[i % 5]);
    end

    // toggling backpressure
    do_reset();
    push(0, 8); push(1, 8);
    for (int k = 0; k < 60; k++) begin
      rdy_v = (k % 2) == 0;
      cycle();
    end
    rdy_v = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    check("s3_beats_out", log_src.size(), 16);
    check("s3_cnt0", cnt0, 8);
    check("s3_cnt1", cnt1, 8);

    // src0 drops out, src1 takes a turn, src0 returns
    do_reset();
    push(0, 2); push(1, 3);
    for (int k = 0; k < 12; k++) begin
      if (k == 4) push(0, 2);
      cycle();
    end
    for (int i = 0; i < 9; i++) check("s4_acc_seq", acc_log[i], exp4[i]);
    check("s4_beats_out", log_src.size(), 7);

    // counter saturation
    do_reset();
    push(0, CMAX + 3);
    for (int k = 0; k < CMAX + 8; k++) cycle();
    check("s5_cnt0_sat", cnt0, CMAX);

    // reset while a beat is stalled in the output register
    do_reset();
    push(0, 4);
    cycle();
    rdy_v = 1'b0;
    cycle();
    cycle();
    check("s6_stalled_valid", bus.out_valid, 1);
    do_reset();
    cycle();
    check("s6_rst_out_valid", bus.out_valid, 0);
    check("s6_rst_cnt0", cnt0, 0);
    acc_log.delete();
    push(1, 1);
    for (int k = 0; k < 4; k++) cycle();
    check("s6_switch_cycle", acc_log[0], 2);
    check("s6_src1_accept", acc_log[1], 1);
    check("s6_out_src", log_src.size() > 0 ? log_src[0] : -1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
